// File: rtl/m72_pkg.sv
// Shared constants for the M72 interrupt controller.
package m72_pkg;

  // I/O register offsets (byte address bits [2:1])
  localparam logic [1:0] INT_REG_EOI    = 2'd0;
  localparam logic [1:0] INT_REG_VEC    = 2'd1;
  localparam logic [1:0] INT_REG_MASK   = 2'd2;
  localparam logic [1:0] INT_REG_RASTER = 2'd3;

  // Interrupt levels; lower index wins
  localparam int unsigned LVL_VBL = 0;
  localparam int unsigned LVL_RAS = 1;

  // Low vector bits per source
  localparam logic [2:0] VEC_VBL_LO  = 3'd0;
  localparam logic [2:0] VEC_RAS_LO  = 3'd2;
  localparam logic [2:0] VEC_SPUR_LO = 3'd7;

  // Lines per frame; raster lines at or beyond this never occur
  localparam logic [8:0] FRAME_LINES = 9'd284;

endpackage

// File: rtl/m72_int_ctrl_if.sv
// CPU I/O register bus seen by the interrupt controller.
interface m72_int_ctrl_if;
  logic        io_cs;
  logic [1:0]  io_addr;
  logic        io_we;
  logic [1:0]  io_sel;
  logic [15:0] io_din;
  logic [15:0] io_dout;
  logic        io_ack;

  modport master (
    output io_cs, io_addr, io_we, io_sel, io_din,
    input  io_dout, io_ack
  );

  modport slave (
    input  io_cs, io_addr, io_we, io_sel, io_din,
    output io_dout, io_ack
  );
endinterface

// File: rtl/m72_line_event.sv
// Beam position compare with a single-clock pulse on the rising edge of the match.
module m72_line_event #(
  parameter logic [8:0] TRIG_H = 9'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [8:0] h_count,
  input  logic [8:0] v_count,
  input  logic [8:0] line,
  input  logic       enable,
  output logic       pulse
);

  logic match;
  logic match_q;

  assign match = enable && (v_count == line) && (h_count == TRIG_H);
  assign pulse = match & ~match_q;

  // Remember the previous match so a held match fires only once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) match_q <= 1'b0;
    else          match_q <= match;
  end

endmodule

// File: rtl/m72_int_ctrl.sv
// M72 interrupt controller: vblank/raster events, priority, ack vectoring, I/O registers.
module m72_int_ctrl
  import m72_pkg::*;
#(
  parameter logic [8:0] VBL_LINE  = 9'd256,
  parameter logic [8:0] TRIG_H    = 9'd0,
  parameter logic [7:0] VEC_RESET = 8'h20
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [8:0]   h_count,
  input  logic [8:0]   v_count,
  m72_int_ctrl_if.slave io,
  output logic         int_rq,
  input  logic         int_ack,
  output logic [7:0]   vector
);

  logic [1:0]  pend_q, pend_d, pend_clr;
  logic [1:0]  isr_q, isr_d, isr_set, isr_clr;
  logic [1:0]  mask_q;
  logic [4:0]  vec_hi_q;
  logic [8:0]  raster_q;
  logic        io_ack_q;
  logic [15:0] io_dout_q;
  logic [15:0] rdata;
  logic        int_rq_q, int_rq_d;
  logic [7:0]  vector_q, vector_d;
  logic        int_ack_q;
  logic        vbl_pulse, ras_pulse;
  logic        access, wr, ack_edge;
  logic [1:0]  eligible;
  logic        unused_din;

  assign unused_din = ^io.io_din[15:9];

  m72_line_event #(.TRIG_H(TRIG_H)) u_vbl_event (
    .clock   (clock),
    .reset_n (reset_n),
    .h_count (h_count),
    .v_count (v_count),
    .line    (VBL_LINE),
    .enable  (1'b1),
    .pulse   (vbl_pulse)
  );

  m72_line_event #(.TRIG_H(TRIG_H)) u_ras_event (
    .clock   (clock),
    .reset_n (reset_n),
    .h_count (h_count),
    .v_count (v_count),
    .line    (raster_q),
    .enable  (raster_q < FRAME_LINES),
    .pulse   (ras_pulse)
  );

  assign access   = io.io_cs & ~io_ack_q;
  assign wr       = access & io.io_we;
  assign ack_edge = int_ack & ~int_ack_q;
  assign eligible = pend_q & ~mask_q;

  assign io.io_ack  = io_ack_q;
  assign io.io_dout = io_dout_q;
  assign int_rq     = int_rq_q;
  assign vector     = vector_q;

  // Ack latching, EOI clearing, request priority and read mux
  always_comb begin
    pend_clr = 2'b00;
    isr_set  = 2'b00;
    isr_clr  = 2'b00;
    vector_d = vector_q;
    rdata    = 16'h0000;

    if (ack_edge) begin
      if (eligible[LVL_VBL]) begin
        pend_clr[LVL_VBL] = 1'b1;
        isr_set[LVL_VBL]  = 1'b1;
        vector_d          = {vec_hi_q, VEC_VBL_LO};
      end else if (eligible[LVL_RAS]) begin
        pend_clr[LVL_RAS] = 1'b1;
        isr_set[LVL_RAS]  = 1'b1;
        vector_d          = {vec_hi_q, VEC_RAS_LO};
      end else begin
        vector_d = {vec_hi_q, VEC_SPUR_LO};
      end
    end

    if (wr && (io.io_addr == INT_REG_EOI) && io.io_sel[0]) begin
      if (isr_q[LVL_VBL])      isr_clr[LVL_VBL] = 1'b1;
      else if (isr_q[LVL_RAS]) isr_clr[LVL_RAS] = 1'b1;
    end

    // A new event in the same cycle as its ack keeps the level pending
    pend_d = (pend_q & ~pend_clr) | {ras_pulse, vbl_pulse};
    isr_d  = (isr_q & ~isr_clr) | isr_set;

    // Raster only requests with nothing in service; vblank only blocked by itself
    int_rq_d = (eligible[LVL_VBL] & ~isr_q[LVL_VBL]) | (eligible[LVL_RAS] & ~|isr_q);

    case (io.io_addr)
      INT_REG_EOI:    rdata = {12'h000, isr_q, pend_q};
      INT_REG_VEC:    rdata = {8'h00, vec_hi_q, VEC_RESET[2:0]};
      INT_REG_MASK:   rdata = {14'h0000, mask_q};
      INT_REG_RASTER: rdata = {7'h00, raster_q};
      default:        rdata = 16'h0000;
    endcase
  end

  // Interrupt state, bus handshake and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= 2'b00;
      isr_q     <= 2'b00;
      int_rq_q  <= 1'b0;
      vector_q  <= VEC_RESET;
      int_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
      io_dout_q <= 16'h0000;
    end else begin
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      int_rq_q  <= int_rq_d;
      vector_q  <= vector_d;
      int_ack_q <= int_ack;
      io_ack_q  <= access;
      if (access) io_dout_q <= rdata;
    end
  end

  // Configuration registers, written on the clock where io_ack rises
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vec_hi_q <= VEC_RESET[7:3];
      mask_q   <= 2'b00;
      raster_q <= 9'd0;
    end else if (wr) begin
      case (io.io_addr)
        INT_REG_VEC:  if (io.io_sel[0]) vec_hi_q <= io.io_din[7:3];
        INT_REG_MASK: if (io.io_sel[0]) mask_q <= io.io_din[1:0];
        INT_REG_RASTER: begin
          if (io.io_sel[0]) raster_q[7:0] <= io.io_din[7:0];
          if (io.io_sel[1]) raster_q[8] <= io.io_din[8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m72_int_ctrl.sv
// Directed bench for the M72 interrupt controller.
module tb_m72_int_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] h_count;
  logic [8:0] v_count;
  logic       int_ack;
  wire        int_rq;
  wire  [7:0] vector;

  int errors = 0;
  int checks = 0;
  logic [15:0] rd;
  logic [7:0]  vec;

  m72_int_ctrl_if bus ();

  m72_int_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .h_count (h_count),
    .v_count (v_count),
    .io      (bus),
    .int_rq  (int_rq),
    .int_ack (int_ack),
    .vector  (vector)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic io_write(input logic [1:0] a, input logic [1:0] s, input logic [15:0] d);
    bus.io_cs = 1'b1; bus.io_we = 1'b1; bus.io_addr = a; bus.io_sel = s; bus.io_din = d;
    tick();
    bus.io_cs = 1'b0; bus.io_we = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [1:0] a, output logic [15:0] d);
    bus.io_cs = 1'b1; bus.io_we = 1'b0; bus.io_addr = a; bus.io_sel = 2'b11;
    tick();
    checks++;
    if (bus.io_ack !== 1'b1) begin
      errors++; $display("FAIL read_ack: got %b want 1", bus.io_ack);
    end
    d = bus.io_dout;
    bus.io_cs = 1'b0;
    tick();
  endtask

  // Pulse int_ack; v = vector after the edge; returns one clock later
  task automatic ack_cycle(output logic [7:0] v);
    int_ack = 1'b1;
    tick();
    v = vector;
    int_ack = 1'b0;
    tick();
  endtask

  // Put the beam on a trigger point for one clock, then move off it
  task automatic event_at(input logic [8:0] line);
    v_count = line; h_count = 9'd0;
    tick();
    h_count = 9'd5;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [15:0] exp);
    io_read(a, rd);
    checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL %s: got %h want %h", name, rd, exp);
    end
  endtask

  task automatic chk_rq(input string name, input logic exp);
    checks++;
    if (int_rq !== exp) begin
      errors++; $display("FAIL %s: int_rq got %b want %b", name, int_rq, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s: vector got %h want %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; h_count = 9'd5; v_count = 9'd0; int_ack = 1'b0;
    bus.io_cs = 1'b0; bus.io_we = 1'b0; bus.io_addr = 2'd0; bus.io_sel = 2'b00;
    bus.io_din = 16'h0000;
    #12;
    chk_rq("reset_rq", 1'b0);
    chk_vec("reset_vector", vector, 8'h20);
    checks++;
    if (bus.io_dout !== 16'h0 || bus.io_ack !== 1'b0) begin
      errors++; $display("FAIL reset_bus: dout %h ack %b want 0 0", bus.io_dout, bus.io_ack);
    end
    tick();
    reset_n = 1'b1;
    tick();
    chk_rd("reset_status", 2'd0, 16'h0000);
    chk_rd("reset_vecbase", 2'd1, 16'h0020);
    chk_rd("reset_mask", 2'd2, 16'h0000);
  endtask

  task automatic test_handshake();
    bus.io_cs = 1'b1; bus.io_we = 1'b0; bus.io_addr = 2'd1;
    tick();
    checks++;
    if (bus.io_ack !== 1'b1) begin errors++; $display("FAIL hs_ack1: got %b want 1", bus.io_ack); end
    tick();
    checks++;
    if (bus.io_ack !== 1'b0) begin errors++; $display("FAIL hs_ack2: got %b want 0", bus.io_ack); end
    tick();
    checks++;
    if (bus.io_ack !== 1'b1) begin errors++; $display("FAIL hs_ack3: got %b want 1", bus.io_ack); end
    bus.io_cs = 1'b0;
    tick();
  endtask

  task automatic test_vblank();
    event_at(9'd256);
    chk_rq("vbl_rq_early", 1'b0);
    tick();
    chk_rq("vbl_rq", 1'b1);
    chk_rd("vbl_pend", 2'd0, 16'h0001);
    ack_cycle(vec);
    chk_vec("vbl_vector", vec, 8'h20);
    chk_rq("vbl_rq_drop", 1'b0);
    chk_rd("vbl_isr", 2'd0, 16'h0004);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("vbl_eoi", 2'd0, 16'h0000);
  endtask

  task automatic test_raster();
    io_write(2'd3, 2'b11, 16'd100);
    io_write(2'd1, 2'b01, 16'h0040);
    chk_rd("ras_vecbase", 2'd1, 16'h0040);
    chk_rd("ras_line", 2'd3, 16'h0064);
    event_at(9'd100);
    tick();
    chk_rq("ras_rq", 1'b1);
    ack_cycle(vec);
    chk_vec("ras_vector", vec, 8'h42);
    chk_rd("ras_isr", 2'd0, 16'h0008);
    event_at(9'd100);
    tick(); tick();
    chk_rq("ras_blocked", 1'b0);
    chk_rd("ras_pend_blocked", 2'd0, 16'h000A);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rq("ras_after_eoi", 1'b1);
    ack_cycle(vec);
    chk_vec("ras_vector2", vec, 8'h42);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("ras_clear", 2'd0, 16'h0000);
  endtask

  task automatic test_both();
    io_write(2'd1, 2'b01, 16'h0020);
    io_write(2'd3, 2'b11, 16'd256);
    event_at(9'd256);
    tick();
    chk_rq("both_rq", 1'b1);
    chk_rd("both_pend", 2'd0, 16'h0003);
    ack_cycle(vec);
    chk_vec("both_first", vec, 8'h20);
    chk_rq("both_ras_held", 1'b0);
    chk_rd("both_state", 2'd0, 16'h0006);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rq("both_after_eoi", 1'b1);
    ack_cycle(vec);
    chk_vec("both_second", vec, 8'h22);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("both_clear", 2'd0, 16'h0000);
  endtask

  task automatic test_preempt();
    io_write(2'd3, 2'b11, 16'd50);
    event_at(9'd50);
    tick();
    ack_cycle(vec);
    chk_vec("pre_ras", vec, 8'h22);
    event_at(9'd256);
    tick();
    chk_rq("pre_vbl_rq", 1'b1);
    ack_cycle(vec);
    chk_vec("pre_vbl", vec, 8'h20);
    chk_rd("pre_isr_both", 2'd0, 16'h000C);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("pre_eoi_vbl_first", 2'd0, 16'h0008);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("pre_clear", 2'd0, 16'h0000);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rd("pre_eoi_idle", 2'd0, 16'h0000);
  endtask

  task automatic test_mask();
    io_write(2'd2, 2'b01, 16'h0001);
    event_at(9'd256);
    tick(); tick();
    chk_rq("mask_rq", 1'b0);
    chk_rd("mask_pend", 2'd0, 16'h0001);
    chk_rd("mask_reg", 2'd2, 16'h0001);
    io_write(2'd2, 2'b01, 16'h0000);
    chk_rq("unmask_rq", 1'b1);
    // New vblank edge lands on the same clock as the ack that clears it
    v_count = 9'd256; h_count = 9'd0; int_ack = 1'b1;
    tick();
    int_ack = 1'b0; h_count = 9'd5;
    tick();
    chk_rd("set_wins", 2'd0, 16'h0005);
    io_write(2'd0, 2'b01, 16'h0);
    chk_rq("set_wins_rq", 1'b1);
    ack_cycle(vec);
    chk_vec("set_wins_vec", vec, 8'h20);
    io_write(2'd0, 2'b01, 16'h0);
    io_write(2'd3, 2'b11, 16'd300);
    event_at(9'd300);
    tick(); tick();
    chk_rq("ras_300_rq", 1'b0);
    chk_rd("ras_300_pend", 2'd0, 16'h0000);
  endtask

  task automatic test_spurious_reset();
    io_write(2'd1, 2'b01, 16'h0048);
    ack_cycle(vec);
    chk_vec("spurious", vec, 8'h4F);
    chk_rd("spurious_state", 2'd0, 16'h0000);
    event_at(9'd256);
    tick();
    chk_rd("pre_reset_vec", 2'd1, 16'h0048);
    v_count = 9'd256; h_count = 9'd0; int_ack = 1'b1;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_rq("async_rst_rq", 1'b0);
    chk_vec("async_rst_vector", vector, 8'h20);
    checks++;
    if (bus.io_dout !== 16'h0 || bus.io_ack !== 1'b0) begin
      errors++; $display("FAIL async_rst_bus: dout %h ack %b want 0 0", bus.io_dout, bus.io_ack);
    end
    int_ack = 1'b0; h_count = 9'd5; v_count = 9'd10;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk_rq("post_rst_rq", 1'b0);
    chk_rd("post_rst_state", 2'd0, 16'h0000);
    chk_rd("post_rst_vec", 2'd1, 16'h0020);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_vblank();
    test_raster();
    test_both();
    test_preempt();
    test_mask();
    test_spurious_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
